// File: rtl/ps2_pkg.sv
// Shared PS/2 host definitions: transmit FSM states, frame edge
// numbering and common keyboard command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQUEST,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_tx_state_e;

  // Device falling-edge numbering inside one host-to-device frame
  localparam logic [3:0] EDGE_START     = 4'd0;
  localparam logic [3:0] EDGE_LAST_DATA = 4'd8;
  localparam logic [3:0] EDGE_PARITY    = 4'd9;
  localparam logic [3:0] EDGE_STOP      = 4'd10;
  localparam logic [3:0] EDGE_MAX       = 4'd11;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data lines plus
// falling-edge detect on the synchronized clock.
module ps2_line_sync (
  input  logic clock,
  input  logic resetn,
  input  logic clk_raw_i,
  input  logic dat_raw_i,
  output logic clk_o,
  output logic dat_o,
  output logic clk_fall_o
);

  logic [1:0] clk_ff_q;
  logic [1:0] dat_ff_q;
  logic       clk_prev_q;

  // Idle bus level is high, so reset to 1 to avoid a false edge
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_ff_q   <= 2'b11;
      dat_ff_q   <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_ff_q   <= {clk_ff_q[0], clk_raw_i};
      dat_ff_q   <= {dat_ff_q[0], dat_raw_i};
      clk_prev_q <= clk_ff_q[1];
    end
  end

  assign clk_o      = clk_ff_q[1];
  assign dat_o      = dat_ff_q[1];
  assign clk_fall_o = clk_prev_q & ~clk_ff_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, request, shift, ack).
// Define PS2_TX_TIMEOUT_EN to abort on a stalled device clock.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES      = 1200,
  parameter int SETUP_CYCLES        = 20,
  parameter int EDGE_TIMEOUT_CYCLES = 20000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int DLY_MAX =
    (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int DW = $clog2(DLY_MAX + 1);
  localparam logic [DW-1:0] INH_LAST = DW'(INHIBIT_CYCLES - 1);
  localparam logic [DW-1:0] SET_LAST = DW'(SETUP_CYCLES - 1);

  logic clk_s;
  logic dat_s;
  logic clk_fall;

  ps2_line_sync u_sync (
    .clock      (clock),
    .resetn     (resetn),
    .clk_raw_i  (ps2_clk_in),
    .dat_raw_i  (ps2_dat_in),
    .clk_o      (clk_s),
    .dat_o      (dat_s),
    .clk_fall_o (clk_fall)
  );

  ps2_tx_state_e   state_q;
  logic [7:0]      sr_q;
  logic            par_q;
  logic [3:0]      edge_q;
  logic [3:0]      edge_d;
  logic [DW-1:0]   dly_q;
  logic            clk_oe_q;
  logic            dat_oe_q;
  logic            ready_q;
  logic            done_q;
  logic            err_q;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TW = $clog2(EDGE_TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(EDGE_TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_q;
  logic          to_watch;
  logic          to_kick;

  always_comb begin
    to_watch = 1'b0;
    to_kick  = 1'b0;
    unique case (state_q)
      ST_SHIFT, ST_ACK: begin
        to_watch = 1'b1;
        to_kick  = clk_fall;
      end
      ST_WAIT_IDLE: begin
        to_watch = 1'b1;
        to_kick  = clk_s & dat_s;
      end
      default: begin
        to_watch = 1'b0;
        to_kick  = 1'b0;
      end
    endcase
  end
`endif

  // Saturating edge count so a misbehaving device cannot wrap it
  always_comb begin
    edge_d = edge_q;
    if (edge_q != EDGE_MAX) begin
      edge_d = edge_q + 4'd1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      sr_q     <= '0;
      par_q    <= 1'b0;
      edge_q   <= '0;
      dly_q    <= '0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      to_q     <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (tx_valid && ready_q) begin
            sr_q     <= tx_data;
            par_q    <= odd_parity(tx_data);
            ready_q  <= 1'b0;
            clk_oe_q <= 1'b1;
            dly_q    <= '0;
            state_q  <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (dly_q == INH_LAST) begin
            dly_q    <= '0;
            dat_oe_q <= 1'b1;
            state_q  <= ST_REQUEST;
          end else begin
            dly_q <= dly_q + 1'b1;
          end
        end
        ST_REQUEST: begin
          if (dly_q == SET_LAST) begin
            dly_q    <= '0;
            clk_oe_q <= 1'b0;
            edge_q   <= EDGE_START;
            state_q  <= ST_SHIFT;
          end else begin
            dly_q <= dly_q + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (clk_fall) begin
            edge_q <= edge_d;
            if (edge_d <= EDGE_LAST_DATA) begin
              dat_oe_q <= ~sr_q[0];
              sr_q     <= {1'b0, sr_q[7:1]};
            end else if (edge_d == EDGE_PARITY) begin
              dat_oe_q <= ~par_q;
            end else begin
              dat_oe_q <= 1'b0;
              state_q  <= ST_ACK;
            end
          end
        end
        ST_ACK: begin
          if (clk_fall) begin
            if (!dat_s) begin
              done_q  <= 1'b1;
              state_q <= ST_WAIT_IDLE;
            end else begin
              err_q   <= 1'b1;
              ready_q <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (clk_s && dat_s) begin
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          clk_oe_q <= 1'b0;
          dat_oe_q <= 1'b0;
          ready_q  <= 1'b1;
          state_q  <= ST_IDLE;
        end
      endcase
`ifdef PS2_TX_TIMEOUT_EN
      // A kick always coincides with any done/error decision above
      if (!to_watch || to_kick) begin
        to_q <= '0;
      end else if (to_q == TO_LAST) begin
        to_q     <= '0;
        err_q    <= 1'b1;
        clk_oe_q <= 1'b0;
        dat_oe_q <= 1'b0;
        ready_q  <= 1'b1;
        state_q  <= ST_IDLE;
      end else begin
        to_q <= to_q + 1'b1;
      end
`endif
    end
  end

  assign tx_ready   = ready_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign tx_done    = done_q;
  assign tx_error   = err_q;

endmodule
